// File: rtl/enigma_frame_buf.sv
// rtl/enigma_frame_buf.sv - frame buffer between the host symbol stream and the enigma core
//
// Loads a frame of 1..DEPTH legal symbols (1..ALPHA) from the host into in_mem, feeds them one
// per cycle to the core, gathers the in-order results into out_mem, then drains them to the
// host under a valid/ready handshake.
//
// Ports:
//   clk_i, rst_i                   clock (rising edge), asynchronous active-low reset
//   start_i, frame_len_i           frame start request and length, sampled only in IDLE
//   wrap_i/wrap_valid_i/wrap_ready_o   host -> buffer symbol stream (ready only in LOAD)
//   in_en_o/in_en_valid_o          buffer -> core symbol beats (registered)
//   out_en_i/out_en_valid_i        core -> buffer results, accepted in FEED/COLLECT
//   wrap_o/wrap_valid_o/wrap_ready_i   buffer -> host result stream (DRAIN)
//   busy_o, done_o, err_o          not-idle, final-beat pulse, sticky error
//
// Configuration: ENIGMA_FRAME_BYPASS_EN adds bypass_i; a bypassed frame goes LOAD -> DRAIN and
// returns in_mem unchanged without touching the core.
module enigma_frame_buf #(
  parameter int SYMB_W = 7,
  parameter int DEPTH  = 128,
  parameter int ALPHA  = 26,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  frame_len_i,
`ifdef ENIGMA_FRAME_BYPASS_EN
  input  logic              bypass_i,
`endif
  input  logic [SYMB_W-1:0] wrap_i,
  input  logic              wrap_valid_i,
  output logic              wrap_ready_o,
  output logic [SYMB_W-1:0] in_en_o,
  output logic              in_en_valid_o,
  input  logic [SYMB_W-1:0] out_en_i,
  input  logic              out_en_valid_i,
  output logic [SYMB_W-1:0] wrap_o,
  output logic              wrap_valid_o,
  input  logic              wrap_ready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FEED, S_COLLECT, S_DRAIN} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]  feed_cnt_q, feed_cnt_d;
  logic [CNT_W-1:0]  ret_cnt_q, ret_cnt_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic              err_q, err_d;
  logic [SYMB_W-1:0] in_en_q, in_en_d;
  logic              in_en_valid_q, in_en_valid_d;
`ifdef ENIGMA_FRAME_BYPASS_EN
  logic              bypass_q, bypass_d;
`endif

  logic [SYMB_W-1:0] in_mem  [DEPTH];
  logic [SYMB_W-1:0] out_mem [DEPTH];

  logic              in_we, out_we;
  logic [AW-1:0]     in_waddr, out_waddr;
  logic [SYMB_W-1:0] drain_data;
  logic              sym_legal, len_ok, ret_ok, drain_beat, drain_last;

  assign sym_legal  = (wrap_i != '0) && (wrap_i <= SYMB_W'(ALPHA));
  assign len_ok     = (frame_len_i != '0) && (frame_len_i <= CNT_W'(DEPTH));
  // Results are only legal while the core has work outstanding and the frame is not yet full.
  assign ret_ok     = ((state_q == S_FEED) || (state_q == S_COLLECT)) && (ret_cnt_q < len_q);
  assign drain_beat = (state_q == S_DRAIN) && wrap_ready_i;
  assign drain_last = drain_beat && ((rd_cnt_q + ONE) == len_q);

`ifdef ENIGMA_FRAME_BYPASS_EN
  assign drain_data = bypass_q ? in_mem[rd_cnt_q[AW-1:0]] : out_mem[rd_cnt_q[AW-1:0]];
`else
  assign drain_data = out_mem[rd_cnt_q[AW-1:0]];
`endif

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    wr_cnt_d      = wr_cnt_q;
    feed_cnt_d    = feed_cnt_q;
    ret_cnt_d     = ret_cnt_q;
    rd_cnt_d      = rd_cnt_q;
    err_d         = err_q;
    in_en_d       = '0;
    in_en_valid_d = 1'b0;
`ifdef ENIGMA_FRAME_BYPASS_EN
    bypass_d      = bypass_q;
`endif
    in_we         = 1'b0;
    in_waddr      = wr_cnt_q[AW-1:0];
    out_we        = 1'b0;
    out_waddr     = ret_cnt_q[AW-1:0];

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (len_ok) begin
            len_d      = frame_len_i;
            err_d      = 1'b0;
            wr_cnt_d   = '0;
            feed_cnt_d = '0;
            ret_cnt_d  = '0;
            rd_cnt_d   = '0;
`ifdef ENIGMA_FRAME_BYPASS_EN
            bypass_d   = bypass_i;
`endif
            state_d    = S_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        // Illegal codes are still handshaken (ready is high) but leave no trace.
        if (wrap_valid_i && sym_legal) begin
          in_we    = 1'b1;
          wr_cnt_d = wr_cnt_q + ONE;
          if ((wr_cnt_q + ONE) == len_q) begin
`ifdef ENIGMA_FRAME_BYPASS_EN
            state_d = bypass_q ? S_DRAIN : S_FEED;
`else
            state_d = S_FEED;
`endif
          end
        end
      end
      S_FEED: begin
        in_en_d       = in_mem[feed_cnt_q[AW-1:0]];
        in_en_valid_d = 1'b1;
        feed_cnt_d    = feed_cnt_q + ONE;
        if ((feed_cnt_q + ONE) == len_q) begin
          state_d = S_COLLECT;
        end
      end
      S_COLLECT: begin
      end
      S_DRAIN: begin
        if (drain_beat) begin
          rd_cnt_d = rd_cnt_q + ONE;
          if (drain_last) begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Evaluated after the FSM so a stray result beat wins over a same-cycle error clear.
    if (out_en_valid_i) begin
      if (ret_ok) begin
        out_we    = 1'b1;
        ret_cnt_d = ret_cnt_q + ONE;
      end else begin
        err_d = 1'b1;
      end
    end

    if ((state_q == S_COLLECT) && (ret_cnt_d == len_q)) begin
      state_d = S_DRAIN;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q       <= S_IDLE;
      len_q         <= '0;
      wr_cnt_q      <= '0;
      feed_cnt_q    <= '0;
      ret_cnt_q     <= '0;
      rd_cnt_q      <= '0;
      err_q         <= 1'b0;
      in_en_q       <= '0;
      in_en_valid_q <= 1'b0;
`ifdef ENIGMA_FRAME_BYPASS_EN
      bypass_q      <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      wr_cnt_q      <= wr_cnt_d;
      feed_cnt_q    <= feed_cnt_d;
      ret_cnt_q     <= ret_cnt_d;
      rd_cnt_q      <= rd_cnt_d;
      err_q         <= err_d;
      in_en_q       <= in_en_d;
      in_en_valid_q <= in_en_valid_d;
`ifdef ENIGMA_FRAME_BYPASS_EN
      bypass_q      <= bypass_d;
`endif
    end
  end

  // RAM contents survive reset; only the counters decide what is valid.
  always_ff @(posedge clk_i) begin
    if (in_we) begin
      in_mem[in_waddr] <= wrap_i;
    end
    if (out_we) begin
      out_mem[out_waddr] <= out_en_i;
    end
  end

  assign wrap_ready_o  = (state_q == S_LOAD);
  assign in_en_o       = in_en_q;
  assign in_en_valid_o = in_en_valid_q;
  assign wrap_valid_o  = (state_q == S_DRAIN);
  assign wrap_o        = wrap_valid_o ? drain_data : '0;
  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = drain_last;
  assign err_o         = err_q;

endmodule

// File: tb/tb_enigma_frame_buf.sv
// tb/tb_enigma_frame_buf.sv - self-checking bench for enigma_frame_buf
module tb_enigma_frame_buf;

  localparam int SYMB_W = 7;
  localparam int DEPTH  = 128;
  localparam int ALPHA  = 26;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b0;
  logic              start_i = 1'b0;
  logic [CNT_W-1:0]  frame_len_i = '0;
  logic [SYMB_W-1:0] wrap_i = '0;
  logic              wrap_valid_i = 1'b0;
  logic              wrap_ready_o;
  logic [SYMB_W-1:0] in_en_o;
  logic              in_en_valid_o;
  logic [SYMB_W-1:0] out_en_i = '0;
  logic              out_en_valid_i = 1'b0;
  logic [SYMB_W-1:0] wrap_o;
  logic              wrap_valid_o;
  logic              wrap_ready_i = 1'b0;
  logic              busy_o;
  logic              done_o;
  logic              err_o;

  enigma_frame_buf #(.SYMB_W(SYMB_W), .DEPTH(DEPTH), .ALPHA(ALPHA), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .frame_len_i(frame_len_i),
    .wrap_i(wrap_i), .wrap_valid_i(wrap_valid_i), .wrap_ready_o(wrap_ready_o),
    .in_en_o(in_en_o), .in_en_valid_o(in_en_valid_o),
    .out_en_i(out_en_i), .out_en_valid_i(out_en_valid_i),
    .wrap_o(wrap_o), .wrap_valid_o(wrap_valid_o), .wrap_ready_i(wrap_ready_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int done_cnt = 0;
  int ret_seen = 0;
  int stray_tok = 0;
  int stray_seen = 0;
  int pidx = 0;
  int rdy_pat [4] = '{1, 1, 1, 1};
  int stim_q [$];
  int exp_in_q [$];
  int exp_out_q [$];
  int got_in_q [$];
  int got_in_cyc_q [$];
  int got_out_q [$];
  logic [SYMB_W:0] d0 = '0;
  logic [SYMB_W:0] d1 = '0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk_i) cyc++;

  // Core stand-in: echo symbol+1 after two cycles; a stray token injects one unsolicited beat.
  always @(posedge clk_i) begin
    #2;
    if (!rst_i) begin
      d0 = '0;
      d1 = '0;
      out_en_valid_i = 1'b0;
      out_en_i = '0;
      stray_seen = stray_tok;
    end else begin
      out_en_valid_i = d1[SYMB_W] | (stray_tok != stray_seen);
      out_en_i = (stray_tok != stray_seen) ? SYMB_W'(9) : SYMB_W'(d1[SYMB_W-1:0] + 7'd1);
      if (d1[SYMB_W]) ret_seen++;
      stray_seen = stray_tok;
      d1 = d0;
      d0 = {in_en_valid_o, in_en_o};
    end
  end

  always @(posedge clk_i) begin
    #1;
    wrap_ready_i = (rdy_pat[pidx % 4] != 0);
    pidx++;
  end

  // Compare process: every in_en beat and every wrap handshake against the frame model.
  always @(negedge clk_i) begin
    if (rst_i) begin
      if (done_o) done_cnt++;
      if (in_en_valid_o) begin
        got_in_q.push_back(int'(in_en_o));
        got_in_cyc_q.push_back(cyc);
        if (exp_in_q.size() == 0) check("in_en_extra_beat", 1, 0);
        else check("in_en", int'(in_en_o), exp_in_q.pop_front());
      end else begin
        check("in_en_zero_when_invalid", int'(in_en_o), 0);
      end
      if (wrap_valid_o) begin
        if (exp_out_q.size() == 0) check("wrap_extra_beat", 1, 0);
        else if (wrap_ready_i) begin
          got_out_q.push_back(int'(wrap_o));
          check("wrap_o", int'(wrap_o), exp_out_q.pop_front());
          check("done_o_on_beat", int'(done_o), int'(exp_out_q.size() == 0));
        end else begin
          check("wrap_o_stall_hold", int'(wrap_o), exp_out_q[0]);
          check("done_o_stall", int'(done_o), 0);
        end
      end else begin
        check("wrap_o_zero_when_invalid", int'(wrap_o), 0);
        check("done_o_when_invalid", int'(done_o), 0);
      end
    end
  end

  task automatic check_all_zero();
    check("rst_busy", int'(busy_o), 0);
    check("rst_wrap_ready", int'(wrap_ready_o), 0);
    check("rst_in_en", int'(in_en_o), 0);
    check("rst_in_en_valid", int'(in_en_valid_o), 0);
    check("rst_wrap_o", int'(wrap_o), 0);
    check("rst_wrap_valid", int'(wrap_valid_o), 0);
    check("rst_done", int'(done_o), 0);
    check("rst_err", int'(err_o), 0);
  endtask

  task automatic start_and_load(input int len, input int stray_at);
    int n;
    n = 0;
    got_in_q.delete();
    got_in_cyc_q.delete();
    got_out_q.delete();
    exp_in_q.delete();
    exp_out_q.delete();
    foreach (stim_q[i]) begin
      if (stim_q[i] >= 1 && stim_q[i] <= ALPHA && n < len) begin
        exp_in_q.push_back(stim_q[i]);
        exp_out_q.push_back(stim_q[i] + 1);
        n++;
      end
    end
    start_i = 1'b1;
    frame_len_i = CNT_W'(len);
    @(posedge clk_i); #1;
    start_i = 1'b0;
    check("busy_after_start", int'(busy_o), 1);
    check("err_cleared_by_start", int'(err_o), 0);
    check("ready_in_load", int'(wrap_ready_o), 1);
    foreach (stim_q[i]) begin
      wrap_i = SYMB_W'(stim_q[i]);
      wrap_valid_i = 1'b1;
      if (i == stray_at) stray_tok++;
      @(posedge clk_i); #1;
    end
    wrap_valid_i = 1'b0;
    wrap_i = '0;
    check("ready_low_after_load", int'(wrap_ready_o), 0);
  endtask

  task automatic run_frame(input int len, input int stray_at, input int exp_err);
    int t;
    int base;
    base = done_cnt;
    start_and_load(len, stray_at);
    t = 0;
    while (done_cnt == base && t < 2000) begin
      @(posedge clk_i); #1;
      t++;
    end
    check("done_seen_in_time", int'(done_cnt != base), 1);
    check("busy_after_done", int'(busy_o), 0);
    check("wrap_valid_after_done", int'(wrap_valid_o), 0);
    check("in_beats_left", exp_in_q.size(), 0);
    check("out_beats_left", exp_out_q.size(), 0);
    check("out_beat_count", got_out_q.size(), len);
    check("err_at_end", int'(err_o), exp_err);
  endtask

  task automatic bad_start(input int len);
    start_i = 1'b1;
    frame_len_i = CNT_W'(len);
    @(posedge clk_i); #1;
    start_i = 1'b0;
    check("bad_len_err", int'(err_o), 1);
    check("bad_len_busy", int'(busy_o), 0);
  endtask

  initial begin
    int t;
    int base;
    repeat (3) @(posedge clk_i);
    #1;
    check_all_zero();
    rst_i = 1'b1;
    @(posedge clk_i); #1;

    // 1: echo +1, latency 2, back-to-back feed
    stim_q = '{1, 2, 3};
    run_frame(3, -1, 0);
    check("t1_in_count", got_in_q.size(), 3);
    check("t1_out_count", got_out_q.size(), 3);
    if (got_in_q.size() == 3) begin
      check("t1_in0", got_in_q[0], 1);
      check("t1_in1", got_in_q[1], 2);
      check("t1_in2", got_in_q[2], 3);
      check("t1_back_to_back", got_in_cyc_q[2] - got_in_cyc_q[0], 2);
    end
    if (got_out_q.size() == 3) begin
      check("t1_out0", got_out_q[0], 2);
      check("t1_out1", got_out_q[1], 3);
      check("t1_out2", got_out_q[2], 4);
    end

    // 2: illegal codes dropped
    stim_q = '{5, 0, 30, 6, 7, 8};
    run_frame(4, -1, 0);
    check("t2_in_count", got_in_q.size(), 4);
    if (got_in_q.size() == 4) begin
      check("t2_in0", got_in_q[0], 5);
      check("t2_in1", got_in_q[1], 6);
      check("t2_in2", got_in_q[2], 7);
      check("t2_in3", got_in_q[3], 8);
    end

    // 3: drain with stalling host
    rdy_pat = '{1, 0, 0, 1};
    stim_q = '{10, 11, 12};
    run_frame(3, -1, 0);
    if (got_out_q.size() == 3) check("t3_out2", got_out_q[2], 13);
    rdy_pat = '{1, 1, 1, 1};

    // 4: bad lengths then recovery
    bad_start(0);
    bad_start(DEPTH + 1);
    stim_q = '{26};
    run_frame(1, -1, 0);
    if (got_out_q.size() == 1) check("t4_out0", got_out_q[0], 27);

    // 5: reset in the middle of COLLECT
    base = ret_seen;
    stim_q = '{1, 2, 3, 4, 5};
    start_and_load(5, -1);
    t = 0;
    while (ret_seen < base + 2 && t < 200) begin
      @(posedge clk_i); #1;
      t++;
    end
    check("t5_two_returned", ret_seen - base, 2);
    check("t5_busy_before_reset", int'(busy_o), 1);
    rst_i = 1'b0;
    #1;
    check_all_zero();
    exp_in_q.delete();
    exp_out_q.delete();
    @(posedge clk_i);
    @(posedge clk_i); #1;
    check_all_zero();
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    check("t5_idle_after_reset", int'(busy_o), 0);
    stim_q = '{3, 4};
    run_frame(2, -1, 0);
    if (got_out_q.size() == 2) begin
      check("t5_out0", got_out_q[0], 4);
      check("t5_out1", got_out_q[1], 5);
    end

    // 6: full-depth frame with a stray result beat during LOAD
    stim_q.delete();
    for (int i = 0; i < DEPTH; i++) stim_q.push_back((i % ALPHA) + 1);
    run_frame(DEPTH, 5, 1);
    if (got_out_q.size() == DEPTH) begin
      check("t6_first", got_out_q[0], 2);
      check("t6_last", got_out_q[DEPTH-1], ((DEPTH - 1) % ALPHA) + 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
